// File: rtl/dcache_pkg.sv
// dcache_pkg: shared field widths, IO boundary, FSM states and line type for the data cache.
package dcache_pkg;
    localparam int OFF_W = 2;
    localparam int IDX_W = 4;
    localparam int TAG_W = 24;
    localparam int WORDS = 4;
    localparam logic [31:0] IO_BASE = 32'h1100_0000;
    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITEBACK,
        S_FILL_REQ,
        S_FILL_WAIT,
        S_IO_WR,
        S_IO_REQ,
        S_IO_WAIT
    } state_e;
    typedef logic [WORDS-1:0][31:0] line_t;
endpackage

// File: rtl/dcache_array.sv
// dcache_array: valid/dirty/tag/data storage with one read port and one line-wide write port.
module dcache_array
    import dcache_pkg::*;
#(
    parameter int LINES = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [IDX_W-1:0] i_ridx,
    output logic             o_valid,
    output logic             o_dirty,
    output logic [TAG_W-1:0] o_tag,
    output line_t            o_data,
    input  logic             i_we,
    input  logic [IDX_W-1:0] i_widx,
    input  logic [TAG_W-1:0] i_wtag,
    input  line_t            i_wdata,
    input  logic             i_wdirty
);
    logic [LINES-1:0] r_valid;
    logic [LINES-1:0] r_dirty;
    logic [TAG_W-1:0] r_tag [LINES];
    line_t            r_data [LINES];
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (i_we) begin
            r_valid[i_widx] <= 1'b1;
            r_dirty[i_widx] <= i_wdirty;
        end
    end
    // Tags and data are deliberately left out of reset; valid gates their use.
    always_ff @(posedge CLK) begin
        if (i_we) begin
            r_tag[i_widx]  <= i_wtag;
            r_data[i_widx] <= i_wdata;
        end
    end
    assign o_valid = r_valid[i_ridx];
    assign o_dirty = r_dirty[i_ridx];
    assign o_tag   = r_tag[i_ridx];
    assign o_data  = r_data[i_ridx];
endmodule

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped write-back write-allocate data cache with an uncached IO window.
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int          LINES   = 16,
    parameter logic [31:0] IO_BASE = dcache_pkg::IO_BASE
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] cpu_addr,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    output logic [31:0] mem_addr,
    output logic        mem_read,
    output logic        mem_write,
    output logic        mem_write_block,
    output logic [31:0] mem_w0_out,
    output logic [31:0] mem_w1_out,
    output logic [31:0] mem_w2_out,
    output logic [31:0] mem_w3_out,
    input  logic [31:0] mem_w0_in,
    input  logic [31:0] mem_w1_in,
    input  logic [31:0] mem_w2_in,
    input  logic [31:0] mem_w3_in
);
    state_e           r_state;
    state_e           w_next;
    logic [OFF_W-1:0] w_off;
    logic [IDX_W-1:0] w_idx;
    logic [TAG_W-1:0] w_tag;
    logic [TAG_W-1:0] w_ltag;
    logic             w_valid;
    logic             w_dirty;
    logic             w_io;
    logic             w_req;
    logic             w_hit;
    logic             w_we;
    line_t            w_line;
    line_t            w_wline;
    assign w_off = cpu_addr[3:2];
    assign w_idx = cpu_addr[7:4];
    assign w_tag = cpu_addr[31:8];
    assign w_io  = cpu_addr >= IO_BASE;
    assign w_req = cpu_rd | cpu_wr;
    assign w_hit = w_valid && (w_ltag == w_tag) && !w_io;
    // A fill cut short by reset must not land in the array.
    assign w_we  = !RST && ((r_state == S_IDLE && cpu_wr && w_hit) || r_state == S_FILL_WAIT);
    always_comb begin
        w_wline        = w_line;
        w_wline[w_off] = cpu_wdata;
        if (r_state == S_FILL_WAIT) w_wline = {mem_w3_in, mem_w2_in, mem_w1_in, mem_w0_in};
    end
    dcache_array #(.LINES(LINES)) u_array (
        .CLK     (CLK),
        .RST     (RST),
        .i_ridx  (w_idx),
        .o_valid (w_valid),
        .o_dirty (w_dirty),
        .o_tag   (w_ltag),
        .o_data  (w_line),
        .i_we    (w_we),
        .i_widx  (w_idx),
        .i_wtag  (w_tag),
        .i_wdata (w_wline),
        .i_wdirty(r_state == S_IDLE)
    );
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:
                if (w_req && w_io) w_next = cpu_wr ? S_IO_WR : S_IO_REQ;
                else if (w_req && !w_hit) w_next = (w_valid && w_dirty) ? S_WRITEBACK : S_FILL_REQ;
            S_WRITEBACK: w_next = S_FILL_REQ;
            S_FILL_REQ:  w_next = S_FILL_WAIT;
            S_IO_REQ:    w_next = S_IO_WAIT;
            default:     w_next = S_IDLE;
        endcase
    end
    always_ff @(posedge CLK) begin
        if (RST) r_state <= S_IDLE;
        else r_state <= w_next;
    end
    always_comb begin
        cpu_rdata       = '0;
        cpu_stall       = 1'b0;
        mem_addr        = '0;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_write_block = 1'b0;
        mem_w0_out      = '0;
        mem_w1_out      = '0;
        mem_w2_out      = '0;
        mem_w3_out      = '0;
        if (!RST) begin
            case (r_state)
                S_IDLE: begin
                    cpu_stall = w_req && !w_hit;
                    cpu_rdata = (w_hit && !cpu_wr) ? w_line[w_off] : '0;
                end
                S_WRITEBACK: begin
                    cpu_stall       = 1'b1;
                    mem_write       = 1'b1;
                    mem_write_block = 1'b1;
                    mem_addr        = {w_ltag, w_idx, 4'b0000};
                    mem_w0_out      = w_line[0];
                    mem_w1_out      = w_line[1];
                    mem_w2_out      = w_line[2];
                    mem_w3_out      = w_line[3];
                end
                S_FILL_REQ: begin
                    cpu_stall = 1'b1;
                    mem_read  = 1'b1;
                    mem_addr  = {w_tag, w_idx, 4'b0000};
                end
                S_FILL_WAIT: cpu_stall = 1'b1;
                S_IO_WR: begin
                    mem_write  = 1'b1;
                    mem_addr   = cpu_addr;
                    mem_w0_out = cpu_wdata;
                end
                S_IO_REQ: begin
                    cpu_stall = 1'b1;
                    mem_read  = 1'b1;
                    mem_addr  = cpu_addr;
                end
                S_IO_WAIT: cpu_rdata = mem_w0_in;
                default: cpu_stall = 1'b0;
            endcase
        end
    end
endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: directed and random checks of dcache_ctrl against a flat-memory reference.
module tb_dcache_ctrl;
    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] cpu_addr;
    logic        cpu_rd;
    logic        cpu_wr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic [31:0] mem_addr;
    logic        mem_read;
    logic        mem_write;
    logic        mem_write_block;
    logic [31:0] mem_w0_out, mem_w1_out, mem_w2_out, mem_w3_out;
    logic [31:0] mem_w0_in, mem_w1_in, mem_w2_in, mem_w3_in;

    int n_vec = 0;
    int n_err = 0;

    dcache_ctrl dut (
        .CLK(CLK), .RST(RST),
        .cpu_addr(cpu_addr), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
        .mem_write_block(mem_write_block),
        .mem_w0_out(mem_w0_out), .mem_w1_out(mem_w1_out),
        .mem_w2_out(mem_w2_out), .mem_w3_out(mem_w3_out),
        .mem_w0_in(mem_w0_in), .mem_w1_in(mem_w1_in),
        .mem_w2_in(mem_w2_in), .mem_w3_in(mem_w3_in)
    );

    always #5 CLK = ~CLK;

    // Unwritten memory holds an address-derived pattern; one IO word is fixed at 0x1234.
    function automatic logic [31:0] dflt(input logic [31:0] a);
        return (a == 32'h1100_0004) ? 32'h0000_1234 : (32'hA500_0000 ^ a);
    endfunction

    logic [31:0] mem [logic [31:0]];
    function automatic logic [31:0] mrd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : dflt(a);
    endfunction
    always @(posedge CLK) begin
        if (mem_read) begin
            mem_w0_in <= mrd(mem_addr);
            mem_w1_in <= mrd(mem_addr + 32'd4);
            mem_w2_in <= mrd(mem_addr + 32'd8);
            mem_w3_in <= mrd(mem_addr + 32'd12);
        end
        if (mem_write) begin
            mem[mem_addr] = mem_w0_out;
            if (mem_write_block) begin
                mem[mem_addr + 32'd4]  = mem_w1_out;
                mem[mem_addr + 32'd8]  = mem_w2_out;
                mem[mem_addr + 32'd12] = mem_w3_out;
            end
        end
    end

    // Reference: flat memory for data, plus which tag each index holds for latency.
    logic [31:0] ref_mem [logic [31:0]];
    bit          rv  [16];
    bit          rdy [16];
    logic [23:0] rt  [16];

    task automatic ref_access(input bit wr, input logic [31:0] a, input logic [31:0] d,
                              output int exp_st, output logic [31:0] exp_rd);
        int i;
        bit hit;
        i = int'(a[7:4]);
        if (a >= 32'h1100_0000) exp_st = wr ? 1 : 2;
        else begin
            hit    = rv[i] && rt[i] == a[31:8];
            exp_st = hit ? 0 : ((rv[i] && rdy[i]) ? 4 : 3);
            rdy[i] = (hit && rdy[i]) || wr;
            rv[i]  = 1'b1;
            rt[i]  = a[31:8];
        end
        exp_rd = ref_mem.exists(a) ? ref_mem[a] : dflt(a);
        if (wr) ref_mem[a] = d;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    int          l_st, n_rd, n_wr;
    logic [31:0] l_rd, a_rd, a_wr, l_w0, l_w2;
    logic        l_blk;

    // Holds a request from posedge+1 until cpu_stall drops, logging memory traffic.
    task automatic access(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d);
        bit done = 0;
        cpu_rd = rd; cpu_wr = wr; cpu_addr = a; cpu_wdata = d;
        l_st = 0; n_rd = 0; n_wr = 0; l_rd = '0; a_rd = '0; a_wr = '0; l_blk = 0; l_w0 = '0; l_w2 = '0;
        for (int c = 0; c < 20; c++) begin
            @(negedge CLK);
            chk("strobe_excl", {31'b0, mem_read && mem_write}, 32'd0);
            if (mem_read) begin n_rd++; a_rd = mem_addr; end
            if (mem_write) begin n_wr++; a_wr = mem_addr; l_blk = mem_write_block; l_w0 = mem_w0_out; l_w2 = mem_w2_out; end
            if (!cpu_stall) begin l_rd = cpu_rdata; done = 1; break; end
            l_st++;
            @(posedge CLK); #1;
        end
        if (!done) chk("timeout", {31'b0, cpu_stall}, 32'd0);
        @(posedge CLK); #1;
        cpu_rd = 0; cpu_wr = 0;
    endtask

    task automatic go(input string tag, input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d);
        int          es;
        logic [31:0] er;
        ref_access(wr, a, d, es, er);
        access(rd, wr, a, d);
        chk({tag, "_stall"}, l_st, es);
        if (!wr) chk({tag, "_rdata"}, l_rd, er);
    endtask

    task automatic quiet(input string tag);
        @(negedge CLK);
        chk({tag, "_stall"}, {31'b0, cpu_stall}, 32'd0);
        chk({tag, "_strobes"}, {29'b0, mem_read, mem_write, mem_write_block}, 32'd0);
        @(posedge CLK); #1;
    endtask

    initial begin
        RST = 1; cpu_rd = 0; cpu_wr = 0; cpu_addr = '0; cpu_wdata = '0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("rst_stall", {31'b0, cpu_stall}, 32'd0);
        chk("rst_rdata", cpu_rdata, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_strobes", {29'b0, mem_read, mem_write, mem_write_block}, 32'd0);
        @(posedge CLK); #1;
        RST = 0;
        quiet("post_rst");

        go("cold", 1, 0, 32'h0000_0104, '0);
        chk("cold_lat", l_st, 32'd3);
        chk("cold_rdata_b", l_rd, 32'hA500_0104);
        chk("cold_raddr", a_rd, 32'h0000_0100);
        chk("cold_traffic", {n_rd[15:0], n_wr[15:0]}, {16'd1, 16'd0});

        go("hit_st", 0, 1, 32'h0000_0108, 32'hDEAD_BEEF);
        chk("hit_st_traffic", {n_rd[15:0], n_wr[15:0]}, 32'd0);
        go("hit_ld", 1, 0, 32'h0000_0108, '0);
        chk("hit_ld_lat", l_st, 32'd0);
        chk("hit_ld_rdata", l_rd, 32'hDEAD_BEEF);
        chk("hit_ld_traffic", {n_rd[15:0], n_wr[15:0]}, 32'd0);

        go("evict", 1, 0, 32'h0000_1100, '0);
        chk("evict_lat", l_st, 32'd4);
        chk("evict_waddr", a_wr, 32'h0000_0100);
        chk("evict_blk", {31'b0, l_blk}, 32'd1);
        chk("evict_w2", l_w2, 32'hDEAD_BEEF);
        chk("evict_raddr", a_rd, 32'h0000_1100);

        go("io_st", 0, 1, 32'h1100_0000, 32'h0000_0055);
        chk("io_st_lat", l_st, 32'd1);
        chk("io_st_waddr", a_wr, 32'h1100_0000);
        chk("io_st_blk", {31'b0, l_blk}, 32'd0);
        chk("io_st_w0", l_w0, 32'h0000_0055);
        chk("io_st_traffic", {n_rd[15:0], n_wr[15:0]}, {16'd0, 16'd1});
        go("no_alloc", 1, 0, 32'h0000_1100, '0);
        chk("no_alloc_lat", l_st, 32'd0);
        go("io_ld", 1, 0, 32'h1100_0004, '0);
        chk("io_ld_lat", l_st, 32'd2);
        chk("io_ld_rdata", l_rd, 32'h0000_1234);
        quiet("idle");

        cpu_rd = 1; cpu_addr = 32'h0000_2200;
        @(posedge CLK); #1;
        @(negedge CLK);
        chk("midrst_fillreq", {31'b0, mem_read}, 32'd1);
        chk("midrst_faddr", mem_addr, 32'h0000_2200);
        @(posedge CLK); #1;
        RST = 1;
        @(negedge CLK);
        chk("midrst_hold_strobes", {29'b0, mem_read, mem_write, mem_write_block}, 32'd0);
        chk("midrst_hold_stall", {31'b0, cpu_stall}, 32'd0);
        @(posedge CLK); #1;
        RST = 0; cpu_rd = 0;
        for (int i = 0; i < 16; i++) rv[i] = 0;
        quiet("midrst_after");
        go("rst_miss", 1, 0, 32'h0000_1100, '0);
        chk("rst_miss_lat", l_st, 32'd3);
        go("rst_miss2", 1, 0, 32'h0000_2200, '0);
        chk("rst_miss2_lat", l_st, 32'd3);

        for (int n = 0; n < 300; n++) begin
            logic [31:0] a;
            bit          rd, wr;
            a  = ($urandom_range(0, 7) == 0) ? (32'h1100_0000 + 32'($urandom_range(0, 3)) * 4)
                                            : {22'd0, 2'($urandom_range(0, 3)), 4'($urandom), 2'($urandom), 2'b00};
            wr = $urandom_range(0, 1) == 1;
            rd = wr ? ($urandom_range(0, 3) == 0) : 1'b1;
            go("rnd", rd, wr, a, $urandom);
            if ($urandom_range(0, 3) == 0) quiet("rnd_idle");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
